// File: rtl/apb_pkg.sv
// Shared types and widths for the command-to-APB bridge and its bus interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  // Bridge FSM: one transaction moves IDLE -> SETUP -> ACCESS (n cycles) -> RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Default APB bus widths; apb_if and apb_master both default to these.
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Width of the ACCESS wait counter. It must hold TIMEOUT-1 without wrapping.
  // A disabled timeout (0) still needs one bit so the counter stays legal.
  function automatic int wait_cnt_w(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus between the bridge (master) and a slave.
// Latency: wires only, no storage.
// Backpressure: the slave stretches ACCESS by holding PREADY low.
interface apb_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );

endinterface

// File: rtl/apb_master.sv
// Command-to-APB bridge: one read/write command at a time, SETUP then ACCESS, result on rsp port.
// Latency: accept edge 0 -> rsp_valid in cycle 3 with zero waits; +1 cycle per slave wait state.
// Backpressure: cmd_ready only in IDLE; RESP holds the response until rsp_ready; timeout aborts a hung slave.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  // APB bus towards the slave
  apb_if.master             bus
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  apb_state_t state;
  apb_state_t state_nxt;

  // Holding registers: drive the bus from SETUP onwards and keep their value afterwards.
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Response registers, stable for the whole RESP state.
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [CNT_W-1:0]  wait_cnt;

  // Decoded events used by both the FSM and the datapath.
  logic take_cmd;
  logic access_done;
  logic access_abort;
  logic timeout_hit;

  // Timeout fires on the last allowed ACCESS cycle; a disabled timeout never fires.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  // State register; reset is immediate so PSEL/PENABLE drop as soon as PRESETn falls.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs (no input reaches an output combinationally).
  always_comb begin
    state_nxt    = state;
    take_cmd     = 1'b0;
    access_done  = 1'b0;
    access_abort = 1'b0;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    bus.PSEL     = 1'b0;
    bus.PENABLE  = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          take_cmd  = 1'b1;
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        bus.PSEL  = 1'b1;
        state_nxt = ACCESS;
      end

      ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        // A ready slave on the timeout cycle still completes cleanly.
        if (bus.PREADY) begin
          access_done = 1'b1;
          state_nxt   = RESP;
        end else if (timeout_hit) begin
          access_abort = 1'b1;
          state_nxt    = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the accepted command; these registers are the bus address/data/direction.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take_cmd) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // Wait counter: cleared when a command is taken, counts ACCESS cycles, saturates.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (take_cmd) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Capture the result: PRDATA only on the PREADY cycle of a read, zero for writes and aborts.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access_done) begin
      rdata_q <= write_q ? '0 : bus.PRDATA;
      err_q   <= 1'b0;
    end else if (access_abort) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign bus.PWRITE = write_q;
  assign bus.PADDR  = addr_q;
  assign bus.PWDATA = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios then random transactions against a transaction-level model.
// Latency: checks accept-to-response timing and per-transaction spacing.
// Backpressure: exercises slave wait states, timeouts and response stalls.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  apb_if bus ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int exp_next_accept = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs one transaction starting at the negedge of an IDLE cycle; returns at the negedge
  // of the IDLE cycle that follows the response handshake.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, input int hold,
                        input bit pend, input bit chain);
    int          t0;
    int          n_acc;
    int          it;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rd;

    // Transaction-level expectations.
    exp_err = (waits >= TO);
    exp_acc = exp_err ? TO : waits + 1;
    exp_rd  = (!wr && !exp_err) ? rd : 32'd0;

    t0 = cyc;
    if (chain) check("accept_cycle", t0, exp_next_accept);
    check("idle_ready", {cmd_ready, bus.PSEL, bus.PENABLE, rsp_valid}, 4'b1000);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    check("setup_bus", {cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
          {3'b010, wr, addr, wd});
    @(negedge PCLK);

    n_acc = 0;
    it    = 0;
    while (rsp_valid !== 1'b1 && it < 40) begin
      it++;
      if (bus.PENABLE === 1'b1) begin
        n_acc++;
        check("access_bus", {cmd_ready, bus.PSEL, bus.PWRITE, bus.PADDR, bus.PWDATA},
              {2'b01, wr, addr, wd});
        bus.PREADY = (n_acc - 1 == waits);
        bus.PRDATA = (n_acc - 1 == waits) ? rd : $urandom;
      end else begin
        bus.PREADY = $urandom;
        bus.PRDATA = $urandom;
      end
      @(negedge PCLK);
    end
    bus.PREADY = $urandom;
    bus.PRDATA = $urandom;

    check("rsp_within_bound", (it < 40), 1'b1);
    check("access_cycles", n_acc, exp_acc);
    check("rsp_latency", cyc - t0, 2 + exp_acc);
    check("rsp_fields", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, exp_err, exp_rd});
    check("resp_bus", {bus.PSEL, bus.PENABLE, cmd_ready, bus.PWRITE, bus.PADDR, bus.PWDATA},
          {3'b000, wr, addr, wd});

    if (pend) begin
      cmd_valid = 1'b1;
      cmd_write = $urandom;
      cmd_addr  = $urandom;
    end
    repeat (hold) begin
      @(negedge PCLK);
      check("rsp_stall", {rsp_valid, rsp_err, rsp_rdata, cmd_ready, bus.PSEL, bus.PENABLE},
            {1'b1, exp_err, exp_rd, 3'b000});
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("after_handshake", {rsp_valid, cmd_ready, bus.PSEL, bus.PENABLE}, 4'b0100);
    exp_next_accept = t0 + 3 + exp_acc + hold;
  endtask

  initial begin
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;

    // Reset values.
    repeat (2) @(negedge PCLK);
    check("reset_outputs",
          {bus.PSEL, bus.PENABLE, bus.PWRITE, rsp_valid, rsp_err, bus.PADDR, bus.PWDATA, rsp_rdata},
          '0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_reset", cmd_ready, 1'b1);

    // Zero-wait write.
    do_txn(1'b1, 32'hFFFF_0F0F, 32'd201, $urandom, 0, 0, 1'b0, 1'b0);
    // Read with 3 wait states.
    do_txn(1'b0, 32'hF0F0_FFFF, $urandom, 32'd201, 3, 0, 1'b0, 1'b1);
    // Timeout: slave never ready.
    do_txn(1'b0, $urandom, $urandom, $urandom, 100, 0, 1'b0, 1'b1);
    // Response backpressure with a pending command, then that command goes through.
    do_txn(1'b0, $urandom, $urandom, $urandom, 1, 5, 1'b1, 1'b1);
    do_txn(1'b1, $urandom, $urandom, $urandom, 0, 0, 1'b0, 1'b1);
    // Back-to-back write then read.
    do_txn(1'b1, $urandom, 32'hA5, $urandom, 0, 0, 1'b0, 1'b1);
    do_txn(1'b0, $urandom, $urandom, $urandom, 0, 0, 1'b0, 1'b1);

    // Reset while in ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = $urandom;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    check("pre_reset_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1 check("reset_drop", {bus.PSEL, bus.PENABLE, rsp_valid, rsp_err, bus.PADDR}, '0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_rerelease", cmd_ready, 1'b1);
    repeat (3) begin
      @(negedge PCLK);
      check("no_stale_rsp", {rsp_valid, bus.PSEL, cmd_ready}, 3'b001);
    end
    do_txn(1'b1, $urandom, $urandom, $urandom, 0, 0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 6),
             $urandom_range(0, 3), (i < 39) ? 1'($urandom) : 1'b0, 1'b1);
    end
    cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
